// File: rtl/dom_and_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dom_and_arbiter                                                          |
// | Round-robin sharing of one bank of masked DOM-indep AND gadgets.         |
// | Optional feature macro: DOM_AND_ARB_FLUSH_EN (bubble between requesters) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dom_and_arbiter #(
  parameter int D    = 2,
  parameter int N    = D + 1,
  parameter int L    = ((D + 1) * D) / 2,
  parameter int W    = 32,
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W*N-1:0] req_a,
  input  logic [NREQ*W*N-1:0] req_b,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  input  logic [W*L-1:0]      rnd_data,
  output logic [W*N-1:0]      gad_a,
  output logic [W*N-1:0]      gad_b,
  output logic [W*L-1:0]      gad_r,
  input  logic [W*N-1:0]      gad_c,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [W*N-1:0]      rsp_c,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] tag1_q, tag1_d;
  logic [NREQ-1:0] tag2_q;
  logic [W*N-1:0]  gad_a_q, gad_a_d;
  logic [W*N-1:0]  gad_b_q, gad_b_d;
  logic [W*L-1:0]  gad_r_q, gad_r_d;

  logic [NREQ-1:0] cand_oh;
  logic [PW-1:0]   cand_idx;
  logic            cand_found;
  logic            block;
  logic            issue;

  // Round-robin search: first pending requester at or above rr_ptr, wrapping.
  always_comb begin
    cand_oh    = '0;
    cand_idx   = '0;
    cand_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cand_found && req_valid[i] && (((int'(rr_ptr_q) + k) % NREQ) == i)) begin
          cand_found  = 1'b1;
          cand_oh[i]  = 1'b1;
          cand_idx    = PW'(i);
        end
      end
    end
  end

`ifdef DOM_AND_ARB_FLUSH_EN
  // A different requester may not follow directly behind the op now in stage 1.
  assign block = (|tag1_q) && ((tag1_q & cand_oh) == '0);
`else
  assign block = 1'b0;
`endif

  assign issue     = rst && rnd_valid && cand_found && (state_q == RUN) && !block;
  assign req_ready = issue ? cand_oh : '0;
  assign rnd_ready = issue;

  always_comb begin
    state_d = RUN;
`ifdef DOM_AND_ARB_FLUSH_EN
    if ((state_q == RUN) && issue && ((req_valid & ~cand_oh) != '0)) begin
      state_d = FLUSH;
    end
`endif
  end

  // AND-OR operand select: an all-zero grant loads zeros, so idle cycles clear the bank inputs.
  always_comb begin
    gad_a_d = '0;
    gad_b_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      gad_a_d = gad_a_d | (req_a[i*W*N +: W*N] & {(W*N){req_ready[i]}});
      gad_b_d = gad_b_d | (req_b[i*W*N +: W*N] & {(W*N){req_ready[i]}});
    end
    gad_r_d  = rnd_data & {(W*L){issue}};
    tag1_d   = req_ready;
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (cand_idx == PW'(NREQ - 1)) ? '0 : cand_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RUN;
      rr_ptr_q <= '0;
      tag1_q   <= '0;
      tag2_q   <= '0;
      gad_a_q  <= '0;
      gad_b_q  <= '0;
      gad_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tag1_q   <= tag1_d;
      tag2_q   <= tag1_q;
      gad_a_q  <= gad_a_d;
      gad_b_q  <= gad_b_d;
      gad_r_q  <= gad_r_d;
    end
  end

  assign gad_a     = gad_a_q;
  assign gad_b     = gad_b_q;
  assign gad_r     = gad_r_q;
  assign rsp_valid = tag2_q;
  assign rsp_c     = gad_c & {(W*N){|tag2_q}};
  assign busy      = (|tag1_q) || (|tag2_q);

endmodule
`default_nettype wire

// File: doc/dom_and_arbiter.md
Name: dom_and_arbiter

Overview:
- Shares one W-bit-wide bank of masked DOM-indep AND gadgets (N = D+1 shares, one-cycle internal register) between NREQ requesters.
- Performs round-robin arbitration and draws one fresh randomness word per issued operation from a PRNG handshake.
- Drives gadget inputs from registers only, zeroed on idle cycles.
- Routes each gadget result back to its requester with a one-hot valid.
- Sits between the masked ALU front-ends and the gadget bank.

Parameters:
- D, 2, probing security order.
- N, D+1, number of shares.
- L, ((D+1)*D)/2, random bits per one-bit gadget.
- W, 32, bit width of one masked operand (number of gadget instances).
- NREQ, 2, number of requesters (1..8).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset: state cleared on a rising clk edge while rst==0.
- req_valid  input  NREQ  requester i has an operation pending.
- req_ready  output  NREQ  one-hot; bit i high in the cycle requester i is accepted.
- req_a  input  NREQ*W*N  operand A shares; requester i slice [i*W*N +: W*N]; bit k share s at [k*N+s].
- req_b  input  NREQ*W*N  operand B shares, same layout.
- rnd_valid  input  1  randomness word available.
- rnd_ready  output  1  randomness word consumed this cycle.
- rnd_data  input  W*L  fresh randomness; gadget k uses [k*L +: L].
- gad_a  output  W*N  registered operand A to gadget bank.
- gad_b  output  W*N  registered operand B to gadget bank.
- gad_r  output  W*L  registered randomness to gadget bank.
- gad_c  input  W*N  gadget bank output (valid one cycle after gad_* presented).
- rsp_valid  output  NREQ  one-hot; result for requester i valid this cycle.
- rsp_c  output  W*N  result shares (pass-through of gad_c, zero when no rsp_valid).
- busy  output  1  any operation in flight (issue or gadget stage).

Behaviour:
- Issue condition in cycle t: any req_valid bit set AND rnd_valid AND FSM in RUN.
- On issue:
  - winner = first requester with req_valid set, searching from rr_ptr upward modulo NREQ.
  - req_ready[winner]=1 and rnd_ready=1, both combinational in cycle t; no other ready bit set.
- Registered at the edge ending cycle t:
  - gad_a/gad_b take the winner's slices; gad_r takes rnd_data.
  - Stage-1 tag = one-hot winner with valid=1.
  - rr_ptr = (winner+1) mod NREQ.
- Randomness: each rnd word is used by exactly one issue and is never reused. If rnd_valid==0, no issue and all ready bits are 0, even with requests pending.
- Idle cycle (no issue): gad_a, gad_b and gad_r registers load all-zero. They never hold stale shares.
- Gadget stage: stage-2 tag <= stage-1 tag at each edge.
- Response: rsp_valid = stage-2 tag. rsp_c = gad_c when any rsp_valid bit is set, else 0 (AND-masked, glitch-free select).
- Latency: acceptance in cycle t -> rsp_valid in cycle t+2.
- Throughput: one issue per cycle.
- Responses have no backpressure; requesters must sink them.
- busy = stage-1 valid OR stage-2 valid.
- FSM states: RUN, FLUSH (FLUSH is reachable only with the optional feature). Without the feature the FSM stays in RUN.
- Simultaneous requests: exactly one is granted per cycle. A requester that keeps req_valid high is granted at least once every NREQ issue cycles.
- NREQ==1: rr_ptr is constant 0.
- Reset (rst==0 at an edge), including mid-operation:
  - gad_a/gad_b/gad_r = 0; stage tags = 0; rr_ptr = 0; FSM = RUN.
  - In-flight operations are dropped with no rsp_valid.
  - While rst==0, req_ready and rnd_ready are held at 0.

Optional Feature:
- Macro: DOM_AND_ARB_FLUSH_EN.
- When defined:
  - After an issue by requester i, an issue by requester j != i in the next cycle is forbidden. The FSM enters FLUSH for exactly one cycle.
  - FLUSH cycle: no issue; gad_* registers load zero; no randomness consumed.
  - Then FSM returns to RUN.
  - Back-to-back issues from the same requester do not flush.
  - Purpose: prevents transitional leakage between different requesters' shares in gadget input/partial-product registers.
- When undefined: FLUSH logic is absent and cross-requester back-to-back issue is allowed.

Test Plan:
- Single op, W=32, N=3: requester 0 sends A=0xF0F0F0F0, B=0xFF00FF00 (random sharings), rnd_valid=1 at cycle 5 -> req_ready[0]=1 and rnd_ready=1 at cycle 5; rsp_valid[0]=1 at cycle 7; XOR of rsp_c shares = 0xF000F000; gad_* all zero at cycles 5 and 8.
- Both requesters valid continuously, rnd_valid=1 -> grants alternate 0,1,0,1; each response appears 2 cycles after its grant with the correct tag.
- Requests pending, rnd_valid=0 for 4 cycles -> no ready bits, gad_* = 0, busy drops after 2 cycles; first issue occurs the cycle rnd_valid rises.
- Reset asserted (rst=0) one cycle after an issue -> no rsp_valid ever for that op; after release, rr_ptr=0 so requester 0 wins a tie.
- DOM_AND_ARB_FLUSH_EN defined, both requesters valid -> grant pattern 0, idle (gad_*=0, rnd_ready=0), 1, idle, 0; requester 0 alone for 3 cycles -> 3 consecutive grants.
- Random regression: 10k ops, random req_valid/rnd_valid -> every unmasked result equals A&B, rnd words never reused, one-hot invariants on req_ready/rsp_valid hold.
